rpn_feeder: RTL and testbench
=============================

RPN_FEEDER -- requirements
Module: rpn_feeder

Interface
REQ-001 Parameter PLEN, default 16, SHALL set the program memory entry count (power of two).
REQ-002 Parameter SDEPTH, default 8, SHALL set the maximum legal operand-stack depth tracked by the feeder.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 wr_en  input  1  SHALL write wr_data into program memory at wr_addr when high.
REQ-006 wr_addr  input  log2(PLEN)  SHALL give the program write address.
REQ-007 wr_data  input  18  SHALL carry a token: [17]=is_op, [16]=unary (only meaningful when is_op), [15:0]=value or ALU opcode.
REQ-008 start  input  1  SHALL request execution of entries 0..len-1.
REQ-009 len  input  log2(PLEN)+1  SHALL give the token count, sampled with start.
REQ-010 num  output  1  SHALL be the opstack push strobe.
REQ-011 op  output  1  SHALL be the opstack operate strobe.
REQ-012 x  output  16  SHALL be the opstack data/opcode bus.
REQ-013 qtop  input  16  SHALL be the opstack top-of-stack value.
REQ-014 busy  output  1  SHALL be high from the start-accept edge until the edge that raises done.
REQ-015 done  output  1  SHALL pulse high for exactly one cycle at the end of every accepted run.
REQ-016 err  output  1  SHALL be valid with done and hold until the next accepted start.
REQ-017 result  output  16  SHALL hold the last captured qtop.

Function
REQ-018 States SHALL be IDLE, ISSUE, SETTLE, ABORT, FINISH.
REQ-019 IDLE: start=1 SHALL be accepted; len=0 -> FINISH with err=1; otherwise load token 0 and go to ISSUE; depth counter cleared and then updated for token 0.
REQ-020 Token i SHALL drive num=~is_op, op=is_op, x=value from accept edge+i until edge+i+1; exactly one token per cycle, no gaps.
REQ-021 Depth update at token launch: push +1; unary op 0, requires depth>=1; binary op -1, requires depth>=2; push at depth==SDEPTH is overflow.
REQ-022 Violating token SHALL NOT be launched: num=op=0, state -> ABORT; next edge -> FINISH with err=1, result unchanged.
REQ-023 After the edge that retires token len-1, state SHALL be SETTLE with num=op=0, x=0.
REQ-024 At the SETTLE exit edge, result SHALL capture qtop, and err SHALL be 1 iff final depth != 1; state -> FINISH.
REQ-025 FINISH SHALL assert done for one cycle, deassert busy, and return to IDLE; a clean run gives done len+1 cycles after the accept edge.
REQ-026 start while not IDLE SHALL be ignored; start in FINISH cycle ignored.
REQ-027 wr_en while busy SHALL be ignored; writes in IDLE take effect for the next run.
REQ-028 num and op SHALL never be high simultaneously; outside ISSUE both SHALL be 0.
REQ-029 Depth counter SHALL be wide enough for SDEPTH+1 without wrap.

Reset
REQ-030 rst SHALL force IDLE, num=op=0, x=0, busy=done=err=0, result=0, depth=0, immediately and asynchronously, including mid-run.
REQ-031 Program memory contents SHALL NOT be cleared by rst.
REQ-032 First start after rst release SHALL be accepted normally.

Verification
REQ-033 Program 2,3,4,MUL(bin),ADD(bin),NEG(unary), len=6, real opstack -> six consecutive token cycles, done 7 cycles after accept, result=16'hFFF2, err=0.
REQ-034 Program 5,ADD(bin), len=2 -> token 5 pushed, ADD not launched (num=op=0), done with err=1, result unchanged.
REQ-035 Program 6,7, len=2 -> result=7, err=1 (final depth 2).
REQ-036 start with len=0 -> done next cycle, err=1, num/op never asserted.
REQ-037 rst asserted during ISSUE of the REQ-033 program -> outputs zero same cycle; rerun after release yields 16'hFFF2.
REQ-038 wr_en to entry 0 and second start during busy -> both ignored; current and next run unaffected.

Source files
------------

// File: rtl/rpn_feeder.sv
// rpn_feeder: streams a stored RPN program into an opstack, tracking operand depth
module rpn_feeder #(
  parameter int PLEN = 16,
  parameter int SDEPTH = 8,
  localparam int AW = $clog2(PLEN),
  localparam int DW = $clog2(SDEPTH + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [17:0]   wr_data,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic          num,
  output logic          op,
  output logic [15:0]   x,
  input  logic [15:0]   qtop,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   result
);
  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, ABORT, FINISH} state_t;
  state_t state_q, state_d;
  logic [17:0] mem [PLEN];
  logic [AW:0] idx_q, idx_d, len_q, len_d, idx_b;
  logic [DW-1:0] dep_q, dep_d, dep_b, dep_n;
  logic num_q, num_d, op_q, op_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [15:0] x_q, x_d, res_q, res_d;
  logic [17:0] tok;
  logic launch, legal;
  assign idx_b = state_q == IDLE ? '0 : idx_q;
  assign dep_b = state_q == IDLE ? '0 : dep_q;
  assign tok = mem[idx_b[AW-1:0]];
  assign launch = state_q == IDLE ? (start && len != '0) : (state_q == ISSUE && idx_q != len_q);
  assign legal = tok[17] ? (dep_b >= (tok[16] ? DW'(1) : DW'(2))) : (dep_b != DW'(SDEPTH));
  assign dep_n = tok[17] ? (tok[16] ? dep_b : dep_b - 1'b1) : dep_b + 1'b1;
  // program memory: host writes only between runs, never cleared by reset
  always_ff @(posedge clk)
    if (wr_en && !busy_q) mem[wr_addr] <= wr_data;
  // next-state: run sequencing, token launch with depth legality check
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    len_d = len_q;
    dep_d = dep_q;
    num_d = 1'b0;
    op_d = 1'b0;
    x_d = '0;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d = err_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (start) begin
        len_d = len;
        err_d = len == '0;
        done_d = len == '0;
        state_d = len == '0 ? FINISH : IDLE;
      end
      ISSUE: state_d = SETTLE;
      SETTLE: begin
        state_d = FINISH;
        res_d = qtop;
        err_d = dep_q != DW'(1);
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      ABORT: begin
        state_d = FINISH;
        err_d = 1'b1;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      busy_d = 1'b1;
      state_d = legal ? ISSUE : ABORT;
      num_d = legal & ~tok[17];
      op_d = legal & tok[17];
      x_d = legal ? tok[15:0] : '0;
      dep_d = legal ? dep_n : dep_b;
      idx_d = idx_b + 1'b1;
    end
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      len_q <= '0;
      dep_q <= '0;
      num_q <= 1'b0;
      op_q <= 1'b0;
      x_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      dep_q <= dep_d;
      num_q <= num_d;
      op_q <= op_d;
      x_q <= x_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      res_q <= res_d;
    end
  assign num = num_q;
  assign op = op_q;
  assign x = x_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign result = res_q;
endmodule

// File: tb/tb_rpn_feeder.sv
// tb_rpn_feeder: scoreboard bench with an RPN evaluator model and a behavioural opstack
module tb_rpn_feeder;
  localparam int PLEN = 16;
  localparam int SDEPTH = 8;
  localparam int AW = 4;
  typedef struct {
    logic [15:0] res;
    logic e;
    int cyc;
  } exp_t;
  logic clk = 0, rst = 1, wr_en = 0, start = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [17:0] wr_data = '0;
  logic [AW:0] len = '0;
  logic num, op, busy, done, err;
  logic [15:0] x, result, qtop;
  int total = 0, bad = 0, ndone = 0, cyc = 0;
  bit skip = 0;
  exp_t exp_done[$];
  exp_t me;
  logic [17:0] exp_tok[$];
  logic [17:0] pmem[PLEN];
  logic [15:0] res_m = '0;
  logic [15:0] stk[$];
  logic [15:0] oa, ob;

  rpn_feeder #(.PLEN(PLEN), .SDEPTH(SDEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .num(num), .op(op), .x(x), .qtop(qtop),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // opcodes: 0 ADD, 1 SUB, 2 MUL (binary); 3 NEG, 4 NOT (unary)
  function automatic logic [15:0] alu(input logic [15:0] opc, input logic [15:0] a, input logic [15:0] b);
    case (opc)
      16'd0: return a + b;
      16'd1: return a - b;
      16'd2: return a * b;
      16'd3: return -a;
      default: return ~a;
    endcase
  endfunction

  function automatic logic [17:0] P(input logic [15:0] v);
    return {2'b00, v};
  endfunction

  function automatic logic [17:0] B(input logic [15:0] o);
    return {2'b10, o};
  endfunction

  function automatic logic [17:0] U(input logic [15:0] o);
    return {2'b11, o};
  endfunction

  function automatic logic [17:0] rtok();
    logic [15:0] o;
    o = 16'($urandom_range(0, 4));
    if ($urandom_range(0, 99) < 60) return P(16'($urandom_range(0, 255)));
    return o < 16'd3 ? B(o) : U(o);
  endfunction

  // the external opstack the feeder drives
  always @(posedge clk or posedge rst)
    if (rst) begin
      stk.delete();
      qtop <= '0;
    end else begin
      if (num) stk.push_back(x);
      else if (op) begin
        ob = stk.pop_back();
        if (x < 16'd3) begin
          oa = stk.pop_back();
          stk.push_back(alu(x, oa, ob));
        end else stk.push_back(alu(x, ob, 16'h0));
      end
      qtop <= stk.size() != 0 ? stk[$] : 16'h0;
    end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // monitor: pops expected tokens and run completions as the DUT presents them
  always @(negedge clk)
    if (!rst && !skip) begin
      if (num || op) begin
        chk("one_strobe", 32'(num & op), 0);
        if (exp_tok.size() == 0) begin
          total++;
          bad++;
          $display("FAIL token_unexpected: got num=%b op=%b x=%h want none", num, op, x);
        end else chk("token", 32'({num, op, x}), 32'(exp_tok.pop_front()));
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected: got done=1 want 0");
        end else begin
          me = exp_done.pop_front();
          chk("result", 32'(result), 32'(me.res));
          chk("err", 32'(err), 32'(me.e));
          chk("done_cycle", cyc, me.cyc);
          chk("busy_at_done", 32'(busy), 0);
          chk("tokens_left", exp_tok.size(), 0);
        end
        ndone++;
      end
    end

  task automatic wr(input int a, input logic [17:0] t);
    @(negedge clk);
    wr_en = 1;
    wr_addr = AW'(a);
    wr_data = t;
    pmem[a] = t;
    @(negedge clk);
    wr_en = 0;
  endtask

  // model evaluates the program as plain RPN, then the run is launched and awaited
  task automatic issue(input int L, input bit inj);
    logic [15:0] st[$];
    logic [15:0] a, b;
    logic [17:0] t;
    exp_t e;
    int k, lat, target;
    bit ab;
    k = L;
    ab = 0;
    for (int i = 0; i < L; i++) begin
      t = pmem[i];
      if (t[17] ? (st.size() < (t[16] ? 1 : 2)) : (st.size() == SDEPTH)) begin
        ab = 1;
        k = i;
        break;
      end
      exp_tok.push_back({~t[17], t[17], t[15:0]});
      if (!t[17]) st.push_back(t[15:0]);
      else if (t[16]) begin
        a = st.pop_back();
        st.push_back(alu(t[15:0], a, 16'h0));
      end else begin
        b = st.pop_back();
        a = st.pop_back();
        st.push_back(alu(t[15:0], a, b));
      end
    end
    e.e = (L == 0) || ab || (st.size() != 1);
    e.res = (L == 0 || ab) ? res_m : st[$];
    lat = L == 0 ? 0 : ab ? k + 1 : L + 1;
    res_m = e.res;
    target = ndone + 1;
    @(negedge clk);
    start = 1;
    len = (AW + 1)'(L);
    @(posedge clk);
    #1;
    e.cyc = cyc + lat;
    exp_done.push_back(e);
    @(negedge clk);
    start = 0;
    if (inj && busy) begin
      wr_en = 1;
      wr_addr = '0;
      wr_data = 18'($urandom);
      start = 1;
      len = (AW + 1)'($urandom_range(1, PLEN));
      @(negedge clk);
      wr_en = 0;
      start = 0;
    end
    for (int i = 0; i < 40 && ndone < target; i++) begin
      @(negedge clk);
      #1;
    end
    if (ndone < target) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done want done within 40 cycles");
      exp_tok.delete();
      exp_done.delete();
    end
  endtask

  task automatic load_neg14();
    wr(0, P(2));
    wr(1, P(3));
    wr(2, P(4));
    wr(3, B(2));
    wr(4, B(0));
    wr(5, U(3));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_flags", 32'({num, op, busy, done, err}), 0);
    chk("rst_x", 32'(x), 0);
    chk("rst_result", 32'(result), 0);
    rst = 0;
    load_neg14();
    issue(6, 1);
    issue(6, 0);
    wr(0, P(5));
    wr(1, B(0));
    issue(2, 0);
    wr(0, P(6));
    wr(1, P(7));
    issue(2, 0);
    issue(0, 0);
    load_neg14();
    skip = 1;
    @(negedge clk);
    start = 1;
    len = 6;
    @(negedge clk);
    start = 0;
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("midrun_rst_flags", 32'({num, op, busy, done, err}), 0);
    chk("midrun_rst_x", 32'(x), 0);
    chk("midrun_rst_result", 32'(result), 0);
    exp_tok.delete();
    exp_done.delete();
    res_m = '0;
    @(negedge clk);
    rst = 0;
    skip = 0;
    issue(6, 0);
    repeat (60) begin
      int L;
      L = $urandom_range(0, PLEN);
      for (int i = 0; i < L; i++) wr(i, rtok());
      issue(L, $urandom_range(0, 3) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1);
  end
endmodule
